sn74xx_mux_reg: RTL and testbench
=================================

// Module: sn74xx_mux_reg
// PURPOSE
//  Parametrised N-channel, W-bit multiplexer with output storage and strobe.
//  Successor to the quad 2:1 '157 selector, in the style of a 74xx298.
//  Adds registered output, channel tag and valid flags.
//  Adds an auto-scan mode that walks all channels in turn.
//  Sits in sn74lib.v beside the combinational 74xx parts.
//  Feeds time-multiplexed consumers such as display scanners and serialisers.
// PARAMETERS
//  WIDTH     4  bits per channel, >=1
//  CHANNELS  2  number of input channels, >=2
//  SELW      derived localparam = $clog2(CHANNELS); not overridable
// PORTS
//  clk    in   1               rising-edge clock; the only clock
//  rst    in   1               reset, asynchronous, active-high
//  d      in   CHANNELS*WIDTH  channel k occupies d[k*WIDTH +: WIDTH]
//  sel    in   SELW            channel select, MANUAL mode only
//  mode   in   1               0 = MANUAL, 1 = SCAN
//  ld     in   1               capture enable; 0 = hold all state
//  str    in   1               strobe, active-high; 1 blanks the capture
//  out    out  WIDTH           registered selected data
//  ch     out  SELW            channel index that produced out
//  valid  out  1               out holds real data (not blanked or invalid)
//  wrap   out  1               1-cycle pulse: SCAN captured channel CHANNELS-1
// BEHAVIOUR
//  Reset (async, any time, including mid-scan):
//   - out=0, ch=0, valid=0, wrap=0.
//   - Scan counter = 0; FSM = MANUAL; mode_q = 0.
//  Latency: 1 clk from d/sel/str to out/ch/valid. No combinational in->out path.
//  FSM has two states, MANUAL and SCAN, plus a mode_q register.
//   - mode sampled each edge.
//   - 0->1 enters SCAN and resets scan counter to 0 in that same edge.
//     That edge captures channel 0.
//   - 1->0 enters MANUAL; scan counter holds its value (ignored).
//  ld=0: out, ch, valid and scan counter hold; wrap=0.
//  MANUAL, ld=1:
//   - ch <= sel.
//   - sel < CHANNELS, str=0: out <= d[sel]; valid <= 1.
//   - sel >= CHANNELS (non-power-of-2 depth): out <= 0; valid <= 0.
//   - str=1: out <= 0; valid <= 0 (strobe overrides sel).
//   - wrap is always 0.
//  SCAN, ld=1:
//   - str=0: out <= d[cnt]; ch <= cnt; valid <= 1.
//     cnt <= (cnt == CHANNELS-1) ? 0 : cnt+1.
//     wrap <= (cnt == CHANNELS-1).
//   - str=1: out <= 0; valid <= 0; wrap <= 0; cnt and ch hold.
//     Blanking pauses the scan; it does not skip channels.
//  Simultaneous mode 0->1 and str=1: enter SCAN with cnt=0 and blank output.
//   - The next un-strobed ld captures channel 0.
//  Counter arithmetic is SELW bits wide; it never reaches CHANNELS.
// STRUCTURE
//  Shared header sn74lib.v holds:
//   - `define SN74_MODE_MANUAL 1'b0 and `define SN74_MODE_SCAN 1'b1
//   - FSM state encodings ST_MANUAL=1'b0 and ST_SCAN=1'b1
//  Sub-module sn74xx_mux_n (WIDTH, CHANNELS):
//   - Combinational N:1 selector; the generalised '157 core.
//   - Outputs 0 on out-of-range select.
//   - Instantiated once, fed by sel or the scan counter.
//  Top level holds the FSM, scan counter, output registers and strobe gating.
// TESTING
//  T1 Reset:
//   - Assert rst mid-SCAN with cnt=2.
//   - Immediately (no clk): out=0, ch=0, valid=0, wrap=0.
//   - After release, first SCAN capture is ch=0.
//  T2 MANUAL (W=4, C=4), d={4'h3,4'hC,4'h5,4'hA}, ld=1, str=0:
//   - sel=0..3 -> out=A,5,C,3 one clk later; valid=1; ch=sel.
//  T3 Strobe, MANUAL, sel=1, str=1, ld=1:
//   - out=0, valid=0.
//   - Next clk with str=0 -> out=5, valid=1.
//  T4 SCAN, mode 0->1, ld=1, str=0, 6 clks:
//   - ch=0,1,2,3,0,1; out=A,5,C,3,A,5.
//   - wrap=1 only on the clk where ch=3.
//  T5 Pause, SCAN, str=1 for 2 clks after ch=1:
//   - out=0, valid=0, ch stays 1.
//   - After str release, next capture is ch=2 (out=C).
//  T6 Non-power-of-2 (C=3, W=8):
//   - MANUAL sel=3 -> out=0, valid=0, ch=3.
//   - SCAN wraps 0,1,2,0; wrap pulses at ch=2.
//   - ld=0 for 3 clks: all outputs hold.

Source files
------------

// File: rtl/sn74xx_mux_reg_pkg.sv
// Shared definitions for the registered N:1 multiplexer family.
// This file holds the mode encodings and the FSM state type.
package sn74xx_mux_reg_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    StManual = 1'b0,
    StScan   = 1'b1
  } state_e;

endpackage

// File: rtl/sn74xx_mux_reg_if.sv
// Bus between a driver of the registered multiplexer and the multiplexer.
// The driver uses the master modport; the multiplexer uses the slave modport.
interface sn74xx_mux_reg_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2
);
  localparam int unsigned SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] d;
  logic [SELW-1:0]           sel;
  logic                      mode;
  logic                      ld;
  logic                      str;
  logic [WIDTH-1:0]          out;
  logic [SELW-1:0]           ch;
  logic                      valid;
  logic                      wrap;

  modport master (output d, sel, mode, ld, str, input out, ch, valid, wrap);
  modport slave  (input d, sel, mode, ld, str, output out, ch, valid, wrap);

endinterface

// File: rtl/sn74xx_mux_n.sv
// Combinational N:1 selector, the generalised '157 core.
// It outputs zero when the select points past the last channel.
module sn74xx_mux_n #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2
) (
  input  logic [CHANNELS*WIDTH-1:0]    d,
  input  logic [$clog2(CHANNELS)-1:0]  sel,
  output logic [WIDTH-1:0]             y
);
  localparam int unsigned SELW = $clog2(CHANNELS);

  always_comb begin
    y = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel == SELW'(k)) y = d[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/sn74xx_mux_reg.sv
// Registered N-channel multiplexer with strobe blanking and an auto-scan mode.
// The FSM, the scan counter and the output registers live here; selection is in sn74xx_mux_n.
module sn74xx_mux_reg
  import sn74xx_mux_reg_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2
) (
  input  logic              clk,
  input  logic              rst,
  sn74xx_mux_reg_if.slave   bus
);
  localparam int unsigned   SELW    = $clog2(CHANNELS);
  localparam logic [SELW:0] ChanLim = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] LastCh = SELW'(CHANNELS - 1);

  state_e           state_q;
  logic [SELW-1:0]  cnt_q;
  logic [WIDTH-1:0] out_q;
  logic [SELW-1:0]  ch_q;
  logic             valid_q;
  logic             wrap_q;

  logic             entering;
  logic [SELW-1:0]  cnt_eff;
  logic [SELW-1:0]  mux_sel;
  logic [WIDTH-1:0] mux_y;
  logic             sel_in_range;

  // Entering SCAN restarts the walk at channel 0 on that very edge.
  always_comb begin
    entering     = (bus.mode == MODE_SCAN) && (state_q == StManual);
    cnt_eff      = entering ? '0 : cnt_q;
    mux_sel      = (bus.mode == MODE_SCAN) ? cnt_eff : bus.sel;
    sel_in_range = {1'b0, bus.sel} < ChanLim;
  end

  sn74xx_mux_n #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_mux (
    .d   (bus.d),
    .sel (mux_sel),
    .y   (mux_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StManual;
      cnt_q   <= '0;
      out_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.ld) begin
      wrap_q <= 1'b0;
      if (bus.mode == MODE_MANUAL) begin
        state_q <= StManual;
        ch_q    <= bus.sel;
        if (bus.str || !sel_in_range) begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          out_q   <= mux_y;
          valid_q <= 1'b1;
        end
      end else begin
        state_q <= StScan;
        if (bus.str) begin
          // Blanking pauses the walk rather than skipping a channel.
          out_q   <= '0;
          valid_q <= 1'b0;
          cnt_q   <= cnt_eff;
        end else begin
          out_q   <= mux_y;
          ch_q    <= cnt_eff;
          valid_q <= 1'b1;
          wrap_q  <= (cnt_eff == LastCh);
          cnt_q   <= (cnt_eff == LastCh) ? '0 : cnt_eff + 1'b1;
        end
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.out   = out_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_sn74xx_mux_reg.sv
// Bench for sn74xx_mux_reg: a 4x4-bit and a 3x8-bit instance, vector tables plus
// randomized traffic checked against a channel-walk reference model.
module tb_sn74xx_mux_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sn74xx_mux_reg_if #(.WIDTH(4), .CHANNELS(4)) bus_a ();
  sn74xx_mux_reg_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();

  sn74xx_mux_reg #(.WIDTH(4), .CHANNELS(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  sn74xx_mux_reg #(.WIDTH(8), .CHANNELS(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit scan;
    int pos;
    int out;
    int ch;
    bit valid;
    bit wrap;
  } mstate_t;

  typedef struct {
    bit mode;
    int sel;
    bit ld;
    bit str;
    int eout;
    int ech;
    bit evalid;
    bit ewrap;
  } vec_t;

  mstate_t m [2];
  int      chans  [2] = '{4, 3};
  int      widths [2] = '{4, 8};
  bit      cur_mode [2];

  function automatic vec_t mk(bit mode, int sel, bit ld, bit str,
                              int eout, int ech, bit evalid, bit ewrap);
    vec_t v;
    v.mode = mode; v.sel = sel; v.ld = ld; v.str = str;
    v.eout = eout; v.ech = ech; v.evalid = evalid; v.ewrap = ewrap;
    return v;
  endfunction

  function automatic void model_reset(int i);
    m[i].scan = 1'b0; m[i].pos = 0; m[i].out = 0;
    m[i].ch = 0; m[i].valid = 1'b0; m[i].wrap = 1'b0;
  endfunction

  function automatic int field(logic [31:0] d, int w, int k);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return int'((d >> (k * w)) & mask);
  endfunction

  // Channel walk expressed directly: position 0..C-1, restarted on entering scan.
  function automatic void model_step(int i, logic [31:0] d, int sel, bit mode, bit ld, bit str);
    int c;
    int w;
    c = chans[i];
    w = widths[i];
    if (!ld) begin
      m[i].wrap = 1'b0;
      return;
    end
    if (mode && !m[i].scan) m[i].pos = 0;
    m[i].scan = mode;
    m[i].wrap = 1'b0;
    if (!mode) begin
      m[i].ch = sel;
      if (str || sel >= c) begin
        m[i].out = 0; m[i].valid = 1'b0;
      end else begin
        m[i].out = field(d, w, sel); m[i].valid = 1'b1;
      end
    end else if (str) begin
      m[i].out = 0; m[i].valid = 1'b0;
    end else begin
      m[i].out   = field(d, w, m[i].pos);
      m[i].ch    = m[i].pos;
      m[i].valid = 1'b1;
      m[i].wrap  = (m[i].pos == c - 1);
      m[i].pos   = (m[i].pos + 1) % c;
    end
  endfunction

  task automatic check(string name, logic [31:0] act, int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(int i, string tag, int eout, int ech, bit evalid, bit ewrap);
    if (i == 0) begin
      check({tag, ".out"},   32'(bus_a.out),   eout);
      check({tag, ".ch"},    32'(bus_a.ch),    ech);
      check({tag, ".valid"}, 32'(bus_a.valid), int'(evalid));
      check({tag, ".wrap"},  32'(bus_a.wrap),  int'(ewrap));
    end else begin
      check({tag, ".out"},   32'(bus_b.out),   eout);
      check({tag, ".ch"},    32'(bus_b.ch),    ech);
      check({tag, ".valid"}, 32'(bus_b.valid), int'(evalid));
      check({tag, ".wrap"},  32'(bus_b.wrap),  int'(ewrap));
    end
  endtask

  task automatic check_model(int i, string tag);
    check_out(i, tag, m[i].out, m[i].ch, m[i].valid, m[i].wrap);
  endtask

  task automatic drive(int i, logic [31:0] d, int sel, bit mode, bit ld, bit str);
    if (i == 0) begin
      bus_a.d = 16'(d); bus_a.sel = 2'(sel); bus_a.mode = mode; bus_a.ld = ld; bus_a.str = str;
    end else begin
      bus_b.d = 24'(d); bus_b.sel = 2'(sel); bus_b.mode = mode; bus_b.ld = ld; bus_b.str = str;
    end
    model_step(i, d, sel, mode, ld, str);
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] DA = 32'h0000_3C5A;
  localparam logic [31:0] DB = 32'h0033_2211;

  vec_t va[$];
  vec_t vb[$];

  initial begin
    // Manual sweep, strobe, scan, pause, hold, simultaneous entry+strobe, one more step.
    va.push_back(mk(0, 0, 1, 0, 'hA, 0, 1, 0));
    va.push_back(mk(0, 1, 1, 0, 'h5, 1, 1, 0));
    va.push_back(mk(0, 2, 1, 0, 'hC, 2, 1, 0));
    va.push_back(mk(0, 3, 1, 0, 'h3, 3, 1, 0));
    va.push_back(mk(0, 1, 1, 1, 'h0, 1, 0, 0));
    va.push_back(mk(0, 1, 1, 0, 'h5, 1, 1, 0));
    va.push_back(mk(1, 0, 1, 0, 'hA, 0, 1, 0));
    va.push_back(mk(1, 0, 1, 0, 'h5, 1, 1, 0));
    va.push_back(mk(1, 0, 1, 0, 'hC, 2, 1, 0));
    va.push_back(mk(1, 0, 1, 0, 'h3, 3, 1, 1));
    va.push_back(mk(1, 0, 1, 0, 'hA, 0, 1, 0));
    va.push_back(mk(1, 0, 1, 0, 'h5, 1, 1, 0));
    va.push_back(mk(1, 0, 1, 1, 'h0, 1, 0, 0));
    va.push_back(mk(1, 0, 1, 1, 'h0, 1, 0, 0));
    va.push_back(mk(1, 0, 1, 0, 'hC, 2, 1, 0));
    va.push_back(mk(1, 0, 1, 0, 'h3, 3, 1, 1));
    va.push_back(mk(1, 0, 0, 0, 'h3, 3, 1, 0));
    va.push_back(mk(0, 2, 1, 0, 'hC, 2, 1, 0));
    va.push_back(mk(1, 0, 1, 1, 'h0, 2, 0, 0));
    va.push_back(mk(1, 0, 1, 0, 'hA, 0, 1, 0));
    va.push_back(mk(1, 0, 1, 0, 'h5, 1, 1, 0));

    // Three-channel instance: out-of-range select, scan wrap, ld=0 hold.
    vb.push_back(mk(0, 3, 1, 0, 'h00, 3, 0, 0));
    vb.push_back(mk(0, 2, 1, 0, 'h33, 2, 1, 0));
    vb.push_back(mk(1, 0, 1, 0, 'h11, 0, 1, 0));
    vb.push_back(mk(1, 0, 1, 0, 'h22, 1, 1, 0));
    vb.push_back(mk(1, 0, 1, 0, 'h33, 2, 1, 1));
    vb.push_back(mk(1, 0, 1, 0, 'h11, 0, 1, 0));
    vb.push_back(mk(1, 0, 0, 0, 'h11, 0, 1, 0));
    vb.push_back(mk(1, 3, 0, 1, 'h11, 0, 1, 0));
    vb.push_back(mk(0, 1, 0, 0, 'h11, 0, 1, 0));

    rst = 1'b1;
    drive(0, DA, 0, 0, 0, 0);
    drive(1, DB, 0, 0, 0, 0);
    model_reset(0);
    model_reset(1);
    #12;
    check_out(0, "reset_a", 0, 0, 0, 0);
    check_out(1, "reset_b", 0, 0, 0, 0);
    rst = 1'b0;

    foreach (va[j]) begin
      drive(0, DA, va[j].sel, va[j].mode, va[j].ld, va[j].str);
      drive(1, DB, 0, 0, 0, 0);
      edge_sample();
      check_out(0, $sformatf("vec_a[%0d]", j), va[j].eout, va[j].ech, va[j].evalid, va[j].ewrap);
      check_model(1, "idle_b");
    end

    // Async reset mid-scan with the counter at 2, then the first capture restarts at 0.
    #3 rst = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    check_out(0, "async_rst_a", 0, 0, 0, 0);
    check_out(1, "async_rst_b", 0, 0, 0, 0);
    #2 rst = 1'b0;
    drive(0, DA, 0, 1, 1, 0);
    drive(1, DB, 0, 0, 0, 0);
    edge_sample();
    check_out(0, "post_rst_scan", 'hA, 0, 1, 0);

    foreach (vb[j]) begin
      drive(0, DA, 0, 1, 0, 0);
      drive(1, DB, vb[j].sel, vb[j].mode, vb[j].ld, vb[j].str);
      edge_sample();
      check_out(1, $sformatf("vec_b[%0d]", j), vb[j].eout, vb[j].ech, vb[j].evalid, vb[j].ewrap);
      check_model(0, "idle_a");
    end

    cur_mode[0] = 1'b1;
    cur_mode[1] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check_out(0, "rnd_rst_a", 0, 0, 0, 0);
        check_out(1, "rnd_rst_b", 0, 0, 0, 0);
        #1 rst = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) cur_mode[i] = ~cur_mode[i];
        drive(i, $urandom, int'($urandom_range(0, 3)), cur_mode[i],
              $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      end
      edge_sample();
      check_model(0, "rnd_a");
      check_model(1, "rnd_b");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
